// File: rtl/fifo_write_packer_pkg.sv
// fifo_write_packer_pkg: shared FIFO word geometry and packed-word type
package fifo_write_packer_pkg;
    localparam int IN_WIDTH_DEF      = 8;
    localparam int RATIO_DEF         = 4;
    localparam int FLUSH_TIMEOUT_DEF = 16;

    function automatic int fifo_data_w(input int iw, input int r);
        return iw * r;
    endfunction

    function automatic int lane_cnt_w(input int r);
        return $clog2(r);
    endfunction

    // a zero timeout still needs a one-bit counter to keep the port legal
    function automatic int timeout_w(input int t);
        return t > 0 ? $clog2(t + 1) : 1;
    endfunction

    localparam int FIFO_DATA_W = fifo_data_w(IN_WIDTH_DEF, RATIO_DEF);

    typedef struct packed {
        logic [FIFO_DATA_W-1:0] data;
        logic [RATIO_DEF-1:0]   keep;
    } packed_word_t;
endpackage

// File: rtl/fifo_write_packer_if.sv
// fifo_write_packer_if: input stream plus FIFO write-side handshake
interface fifo_write_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_WIDTH-1:0]       in_data;
    logic                      in_last;
    logic                      full;
    logic                      inc;
    logic [IN_WIDTH*RATIO-1:0] wdata;
    logic [RATIO-1:0]          wkeep;

    modport master (
        output in_valid, in_data, in_last, full,
        input  in_ready, inc, wdata, wkeep
    );

    modport slave (
        input  in_valid, in_data, in_last, full,
        output in_ready, inc, wdata, wkeep
    );
endinterface

// File: rtl/fifo_write_packer_lane_accum.sv
// fifo_lane_accum: gathers narrow words into lanes and decides when a word closes
module fifo_lane_accum
    import fifo_write_packer_pkg::*;
#(
    parameter int IN_WIDTH      = IN_WIDTH_DEF,
    parameter int RATIO         = RATIO_DEF,
    parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic [IN_WIDTH-1:0]                    in_data,
    input  logic                                   in_last,
    input  logic                                   slot_free,
    output logic                                   in_ready,
    output logic                                   push,
    output logic [fifo_data_w(IN_WIDTH, RATIO)-1:0] push_data,
    output logic [RATIO-1:0]                       push_keep
);
    localparam int DW = fifo_data_w(IN_WIDTH, RATIO);
    localparam int CW = lane_cnt_w(RATIO);
    localparam int TW = timeout_w(FLUSH_TIMEOUT);

    logic [DW-1:0]    acc_data, nxt_data;
    logic [RATIO-1:0] acc_keep, nxt_keep;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    idle;
    logic             acc_done, accept, timeout, close;

    assign in_ready  = !acc_done;
    assign accept    = in_valid && !acc_done;
    // an accept always wins over a flush, so the arriving word joins the partial
    assign timeout   = FLUSH_TIMEOUT != 0 && !accept && !acc_done && cnt != '0 &&
                       idle == TW'(FLUSH_TIMEOUT);
    assign close     = accept ? (cnt == CW'(RATIO - 1) || in_last) : timeout;
    assign nxt_data  = accept ? acc_data | (DW'(in_data) << (IN_WIDTH * cnt)) : acc_data;
    assign nxt_keep  = accept ? acc_keep | (RATIO'(1) << cnt) : acc_keep;
    // a parked word or a freshly closed one moves out whenever the slot frees
    assign push      = (acc_done || close) && slot_free;
    assign push_data = nxt_data;
    assign push_keep = nxt_keep;

    // lane accumulator: clear on handoff, park on blocked close, else fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_keep <= '0;
            cnt      <= '0;
            acc_done <= 1'b0;
        end else if (push) begin
            acc_data <= '0;
            acc_keep <= '0;
            cnt      <= '0;
            acc_done <= 1'b0;
        end else if (close) begin
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
            cnt      <= '0;
            acc_done <= 1'b1;
        end else if (accept) begin
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
            cnt      <= cnt + 1'b1;
        end
    end

    // idle counter: runs only while a partial word waits for more lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle <= '0;
        else
            idle <= (accept || close || acc_done || cnt == '0 || FLUSH_TIMEOUT == 0) ? '0 : idle + 1'b1;
    end
endmodule

// File: rtl/fifo_write_packer.sv
// fifo_write_packer: packs narrow stream words into keep-masked FIFO writes
module fifo_write_packer
    import fifo_write_packer_pkg::*;
#(
    parameter int IN_WIDTH      = IN_WIDTH_DEF,
    parameter int RATIO         = RATIO_DEF,
    parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
    input logic                clk,
    input logic                rst_n,
    fifo_write_packer_if.slave bus
);
    localparam int DW = fifo_data_w(IN_WIDTH, RATIO);

    logic [DW-1:0]    out_data, push_data;
    logic [RATIO-1:0] out_keep, push_keep;
    logic             out_valid, fire, push;

    assign fire      = out_valid && !bus.full;
    assign bus.inc   = fire;
    assign bus.wdata = out_data;
    assign bus.wkeep = out_keep;

    fifo_lane_accum #(
        .IN_WIDTH      (IN_WIDTH),
        .RATIO         (RATIO),
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_data   (bus.in_data),
        .in_last   (bus.in_last),
        .slot_free (!out_valid || fire),
        .in_ready  (bus.in_ready),
        .push      (push),
        .push_data (push_data),
        .push_keep (push_keep)
    );

    // output slot: load on push, empty after a write with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (push) begin
            out_data  <= push_data;
            out_keep  <= push_keep;
            out_valid <= 1'b1;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_write_packer.sv
// tb_fifo_write_packer: scoreboard bench for the write-side packer
module tb_fifo_write_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_wr = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } ew_t;

    ew_t         exp_q[$];
    logic [7:0]  part[$];
    int          m_idle = 0;

    fifo_write_packer_if #(.IN_WIDTH(8), .RATIO(4)) bus();

    fifo_write_packer #(.IN_WIDTH(8), .RATIO(4), .FLUSH_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void close_word();
        ew_t e;
        e.data = '0;
        foreach (part[i]) e.data[i*8 +: 8] = part[i];
        e.keep = 4'((1 << part.size()) - 1);
        exp_q.push_back(e);
        part.delete();
    endfunction

    // reference: up to 4 lanes, closed by last, a full word, or 16 idle waiting cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            part.delete();
            exp_q.delete();
            m_idle = 0;
        end else if (bus.in_valid && bus.in_ready) begin
            part.push_back(bus.in_data);
            m_idle = 0;
            if (part.size() == 4 || bus.in_last) close_word();
        end else if (part.size() > 0 && bus.in_ready) begin
            if (m_idle == 16) begin
                close_word();
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    end

    // monitor: every FIFO write must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && bus.inc) begin
            ew_t e;
            n_wr++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h/%0h expected no write", bus.wdata, bus.wkeep);
            end else begin
                e = exp_q.pop_front();
                chk("sb_word", 64'({bus.wkeep, bus.wdata}), 64'({e.keep, e.data}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, output int waits);
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        waits = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            if (!ok) waits++;
            tick();
        end while (!ok && waits < 100);
        if (!ok) chk("send_timeout", 64'(ok), 64'(1));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        int w, stalls, w0, k;
        logic early, acc;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.full     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inc", 64'(bus.inc), 64'(0));
        chk("rst_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_wdata", 64'(bus.wdata), 64'(0));
        chk("rst_wkeep", 64'(bus.wkeep), 64'(0));
        rst_n = 1'b1;
        tick();

        send(8'h11, 0, w); send(8'h22, 0, w); send(8'h33, 0, w); send(8'h44, 0, w);
        @(negedge clk);
        chk("full_word_inc", 64'(bus.inc), 64'(1));
        chk("full_word_data", 64'(bus.wdata), 64'h44332211);
        chk("full_word_keep", 64'(bus.wkeep), 64'hf);
        @(negedge clk);
        chk("full_word_once", 64'(bus.inc), 64'(0));
        tick();

        send(8'hAA, 0, w); send(8'hBB, 1, w);
        @(negedge clk);
        chk("last_inc", 64'(bus.inc), 64'(1));
        chk("last_data", 64'(bus.wdata), 64'h0000BBAA);
        chk("last_keep", 64'(bus.wkeep), 64'h3);
        tick();

        send(8'h5C, 0, w);
        early = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (bus.inc) early = 1'b1;
        end
        chk("timeout_early", 64'(early), 64'(0));
        @(negedge clk);
        chk("timeout_inc", 64'(bus.inc), 64'(1));
        chk("timeout_data", 64'(bus.wdata), 64'h5C);
        chk("timeout_keep", 64'(bus.wkeep), 64'h1);
        tick();

        bus.full = 1'b1;
        stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 0, w);
            stalls += w;
        end
        chk("fullhold_stalls", 64'(stalls), 64'(0));
        @(negedge clk);
        chk("fullhold_ready", 64'(bus.in_ready), 64'(0));
        chk("fullhold_inc", 64'(bus.inc), 64'(0));
        tick();
        bus.full = 1'b0;
        @(negedge clk);
        chk("release_w1", 64'({bus.inc, bus.wdata}), {31'd0, 1'b1, 32'h04030201});
        tick();
        @(negedge clk);
        chk("release_w2", 64'({bus.inc, bus.wdata}), {31'd0, 1'b1, 32'h08070605});
        tick();
        for (int i = 9; i <= 12; i++) send(8'(i), 0, w);
        repeat (3) tick();

        w0 = n_wr;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom), 0, w);
            stalls += w;
        end
        repeat (3) tick();
        chk("stream_stalls", 64'(stalls), 64'(0));
        chk("stream_writes", 64'(n_wr - w0), 64'(4));

        bus.full = 1'b1;
        send(8'h11, 0, w); send(8'h22, 0, w); send(8'h33, 0, w); send(8'h44, 0, w);
        send(8'h55, 0, w); send(8'h66, 0, w);
        bus.full = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_inc", 64'(bus.inc), 64'(0));
        chk("midrst_ready", 64'(bus.in_ready), 64'(1));
        chk("midrst_wdata", 64'(bus.wdata), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(8'hA1, 0, w); send(8'hA2, 0, w); send(8'hA3, 0, w); send(8'hA4, 0, w);
        @(negedge clk);
        chk("postrst_word", 64'({bus.inc, bus.wkeep, bus.wdata}), {27'd0, 1'b1, 4'hf, 32'hA4A3A2A1});
        tick();

        k = 0;
        while (k < 1500) begin
            if (($urandom % 40) == 0) begin
                bus.in_valid = 1'b0;
                bus.full     = 1'b0;
                repeat ($urandom_range(10, 22)) tick();
                k += 20;
            end
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom % 3) != 0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = ($urandom % 6) == 0;
            end
            bus.full = ($urandom % 4) == 0;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
            k++;
        end

        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.full     = 1'b0;
        k = 0;
        while ((exp_q.size() != 0 || part.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        repeat (2) tick();
        chk("drain_queue", 64'(exp_q.size()), 64'(0));
        chk("drain_partial", 64'(part.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
